ifetch_responder: RTL

Memory-side responder for the program counter's fetch handshake. It takes the current instruction address `PCaddr`, runs a read on the instruction-memory bus, and captures the returned word into `instr`. It then pulses `iready` for one cycle, which lets the PC advance. It sits between the PC/decode front end and the shared memory bus, and yields to data-memory traffic before starting a fetch.

---
 rtl/ifetch_responder_if.sv | 40 ++++
 rtl/ifetch_responder.sv | 111 +++++++++++
 2 files changed

// File: rtl/ifetch_responder_if.sv
// Fetch handshake between the PC/decode front end and the instruction-memory bus.
// The slave modport is the responder's view, the master modport is the environment's view.
interface ifetch_responder_if;
    logic [31:0] PCaddr;
    logic        dmem_active;
    logic        mem_busy;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] instr;
    logic        iready;
    logic        fault;
    logic [1:0]  fault_code;

    modport slave (
        input  PCaddr,
        input  dmem_active,
        input  mem_busy,
        input  mem_rdata,
        output mem_read,
        output mem_addr,
        output instr,
        output iready,
        output fault,
        output fault_code
    );

    modport master (
        output PCaddr,
        output dmem_active,
        output mem_busy,
        output mem_rdata,
        input  mem_read,
        input  mem_addr,
        input  instr,
        input  iready,
        input  fault,
        input  fault_code
    );
endinterface

// File: rtl/ifetch_responder.sv
// Memory-side fetch responder: reads the word at PCaddr, captures it into instr and pulses iready.
// Yields to data-memory traffic before starting a fetch; faults on misaligned PC or bus timeout.
module ifetch_responder #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               nRST,
    ifetch_responder_if.slave  bus
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CODE_W  = 2;

    localparam logic [CNT_W-1:0]  WAIT_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [CODE_W-1:0] CODE_NONE     = 2'b00;
    localparam logic [CODE_W-1:0] CODE_MISALIGN = 2'b01;
    localparam logic [CODE_W-1:0] CODE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2,
        FAULT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [XLEN-1:0]    instr_q, instr_d;
    logic [CODE_W-1:0]  code_q, code_d;

    logic               mem_read_q;
    logic [XLEN-1:0]    mem_addr_q;
    logic               iready_q;
    logic               fault_q;

    // Next-state, wait counter, capture and fault-code latching.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        instr_d    = instr_q;
        code_d     = code_q;

        unique case (state_q)
            IDLE: begin
                // Misalignment outranks bus arbitration.
                if (bus.PCaddr[1:0] != 2'b00) begin
                    state_d = FAULT;
                    code_d  = CODE_MISALIGN;
                end else if (!bus.dmem_active) begin
                    state_d    = FETCH;
                    wait_cnt_d = '0;
                end
            end
            FETCH: begin
                // Returned data in the last allowed cycle still wins over the timeout.
                if (!bus.mem_busy) begin
                    instr_d = bus.mem_rdata;
                    state_d = READY;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = FAULT;
                    code_d  = CODE_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            READY: begin
                state_d = IDLE;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and outputs; outputs are decoded from the state being entered so they
    // are registered yet line up exactly with the state they describe.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            instr_q    <= NOP;
            code_q     <= CODE_NONE;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            iready_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            instr_q    <= instr_d;
            code_q     <= code_d;
            mem_read_q <= (state_d == FETCH);
            mem_addr_q <= (state_d == FETCH) ? bus.PCaddr : '0;
            iready_q   <= (state_d == READY);
            fault_q    <= (state_d == FAULT);
        end
    end

    assign bus.mem_read   = mem_read_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.instr      = instr_q;
    assign bus.iready     = iready_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;

endmodule
